// File: rtl/sca_blk_pkg.sv
// ---------------------------------------------------------------------------
// sca_blk_pkg
// Shared constants and helpers for the SCA block allocator:
//   BLK_W      - width of an SCA block index
//   MAX_BLK    - largest pool the index width can address
//   FIFO_DEPTH - depth of the free-pool and digitise-queue FIFOs
//   CNT_W      - width of a FIFO occupancy count (0..FIFO_DEPTH)
//   preload_list() - reset contents of the free pool (blocks 1..nblk-1)
// ---------------------------------------------------------------------------
package sca_blk_pkg;

    localparam int unsigned BLK_W      = 4;
    localparam int unsigned MAX_BLK    = 16;
    localparam int unsigned FIFO_DEPTH = 16;
    localparam int unsigned CNT_W      = 5;

    typedef logic [BLK_W-1:0]                  blk_t;
    typedef logic [FIFO_DEPTH-1:0][BLK_W-1:0]  blk_list_t;

    // Block 0 is the block being written out of reset, so the free pool holds the rest.
    function automatic blk_list_t preload_list(input int unsigned nblk);
        blk_list_t l;
        l = '0;
        for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            if (i + 1 < nblk) begin
                l[i] = blk_t'(i + 1);
            end
        end
        return l;
    endfunction

endpackage

// File: rtl/blk_fifo.sv
// ---------------------------------------------------------------------------
// blk_fifo
// 16 x 4 synchronous FIFO of SCA block indices, first-word fall-through.
//   CLK, RST    - clock, asynchronous active-high reset
//   push_i/din_i - write port; a push to a full FIFO is dropped (drop_o)
//                  unless a pop happens in the same cycle
//   pop_i       - read port; ignored while empty
//   dout_o      - head entry, valid while !empty_o
//   cnt_o       - registered occupancy, cnt_d_o its next-state value
// PRELOAD=1 fills the FIFO with blocks 1..NBLK-1 on reset.
// TMR=1 triplicates the pointer/count registers with majority voting.
// ---------------------------------------------------------------------------
module blk_fifo
    import sca_blk_pkg::*;
#(
    parameter bit          PRELOAD = 1'b0,
    parameter int unsigned NBLK    = 12,
    parameter int unsigned TMR     = 0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             push_i,
    input  blk_t             din_i,
    input  logic             pop_i,
    output blk_t             dout_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] cnt_o,
    output logic [CNT_W-1:0] cnt_d_o,
    output logic             drop_o
);

    localparam blk_list_t        MemRst = PRELOAD ? preload_list(NBLK) : '0;
    localparam logic [CNT_W-1:0] CntRst = PRELOAD ? CNT_W'(NBLK - 1) : '0;
    // Control word layout: {wptr, rptr, cnt}
    localparam logic [12:0]      CtlRst = {CntRst[3:0], 4'd0, CntRst};

    blk_list_t   mem_q, mem_d;
    logic [12:0] ctl_d, ctl_v;
    logic [3:0]  wptr, rptr;
    logic [4:0]  cnt;
    logic        full, pop_eff, push_eff;

    assign {wptr, rptr, cnt} = ctl_v;

    always_comb begin
        empty_o  = (cnt == '0);
        full     = (cnt == CNT_W'(FIFO_DEPTH));
        pop_eff  = pop_i && !empty_o;
        push_eff = push_i && (!full || pop_eff);
        drop_o   = push_i && !push_eff;
        mem_d    = mem_q;
        if (push_eff) begin
            mem_d[wptr] = din_i;
        end
        unique case ({push_eff, pop_eff})
            2'b10:   cnt_d_o = cnt + 5'd1;
            2'b01:   cnt_d_o = cnt - 5'd1;
            default: cnt_d_o = cnt;
        endcase
        ctl_d = {wptr + {3'b000, push_eff}, rptr + {3'b000, pop_eff}, cnt_d_o};
    end

    assign dout_o = mem_q[rptr];
    assign cnt_o  = cnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mem_q <= MemRst;
        end else begin
            mem_q <= mem_d;
        end
    end

    if (TMR != 0) begin : g_tmr
        logic [12:0] ctl_q [3];
        for (genvar k = 0; k < 3; k++) begin : g_rep
            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    ctl_q[k] <= CtlRst;
                end else begin
                    ctl_q[k] <= ctl_d;
                end
            end
        end
        assign ctl_v = (ctl_q[0] & ctl_q[1]) | (ctl_q[0] & ctl_q[2]) | (ctl_q[1] & ctl_q[2]);
    end else begin : g_single
        logic [12:0] ctl_q;
        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                ctl_q <= CtlRst;
            end else begin
                ctl_q <= ctl_d;
            end
        end
        assign ctl_v = ctl_q;
    end

endmodule

// File: rtl/sca_blk_alloc.sv
// ---------------------------------------------------------------------------
// sca_blk_alloc
// SCA storage-block pool manager downstream of the block-cycle controller.
//   CLK, RST        - clock, asynchronous active-high reset
//   NBSEL, ENAREG   - controller strobes: pop next free block / advance CURBLK
//   LCTYENA, NOLCT  - current block goes to the digitise queue / back to free pool
//   RTN_VLD/RTN_BLK - digitiser returns a block, RTN_ACK pulses one cycle later
//   DQ_RD/DQ_BLK/DQ_EMPTY - FWFT digitise queue towards the digitiser
//   CURBLK          - block currently being written
//   DSCAFULL/DLSCAFULL - free pool empty / at or below LOWMARK
//   OVFL            - sticky error: LCT block lost, full push, or bad return
//   FREECNT         - free-pool occupancy
// Optional macro SCA_BLK_DUPCHK_EN adds an in-use bitmap that rejects
// returns of blocks that are not currently allocated.
// ---------------------------------------------------------------------------
module sca_blk_alloc
    import sca_blk_pkg::*;
#(
    parameter int unsigned NBLK    = 12,
    parameter int unsigned LOWMARK = 2,
    parameter int unsigned TMR     = 0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             NBSEL,
    input  logic             ENAREG,
    input  logic             LCTYENA,
    input  logic             NOLCT,
    input  logic             RTN_VLD,
    input  logic [BLK_W-1:0] RTN_BLK,
    output logic             RTN_ACK,
    input  logic             DQ_RD,
    output logic [BLK_W-1:0] DQ_BLK,
    output logic             DQ_EMPTY,
    output logic [BLK_W-1:0] CURBLK,
    output logic             DSCAFULL,
    output logic             DLSCAFULL,
    output logic             OVFL,
    output logic [CNT_W-1:0] FREECNT
);

    localparam bit DscaRst  = (NBLK - 1 == 0);
    localparam bit DlscaRst = (NBLK - 1 <= LOWMARK);

    blk_t             curblk_q, curblk_d, nxtblk_q, nxtblk_d;
    logic             nxt_vld_q, nxt_vld_d;
    logic             ovfl_q, ovfl_d, rtn_ack_q, rtn_ack_d;
    logic             dsca_q, dsca_d, dlsca_q, dlsca_d;
    logic             nolct_ok, rtn_ok, nolct_push, rtn_take, rtn_push, bad_blk, lct_lost;
    logic             free_push, free_pop, free_empty, free_drop, dq_push, dq_drop;
    blk_t             free_head, free_din;
    logic [CNT_W-1:0] free_cnt_d, dq_cnt, dq_cnt_d;
    logic             unused_dq;

    always_comb begin
        curblk_d  = curblk_q;
        nxtblk_d  = nxtblk_q;
        nxt_vld_d = nxt_vld_q;
        if (ENAREG) begin
            // Without a fresh block the current one is simply overwritten.
            if (nxt_vld_q) begin
                curblk_d = nxtblk_q;
            end
            nxt_vld_d = 1'b0;
        end
        free_pop = NBSEL && !free_empty;
        if (NBSEL) begin
            nxt_vld_d = !free_empty;
            if (!free_empty) begin
                nxtblk_d = free_head;
            end
        end
        // An LCT block can only be kept if there is somewhere else to write next.
        dq_push    = LCTYENA && nxt_vld_d;
        lct_lost   = LCTYENA && !nxt_vld_d;
        nolct_push = NOLCT && nolct_ok;
        rtn_take   = RTN_VLD && !nolct_push;
        rtn_push   = rtn_take && rtn_ok;
        bad_blk    = (NOLCT && !nolct_ok) || (rtn_take && !rtn_ok);
        free_push  = nolct_push || rtn_push;
        free_din   = nolct_push ? curblk_q : RTN_BLK;
        rtn_ack_d  = rtn_take;
    end

    // Kept apart from the block above: these depend on FIFO outputs fed by it.
    assign ovfl_d  = ovfl_q | lct_lost | bad_blk | free_drop | dq_drop;
    assign dsca_d  = (free_cnt_d == '0);
    assign dlsca_d = (free_cnt_d <= CNT_W'(LOWMARK));

`ifdef SCA_BLK_DUPCHK_EN
    logic [MAX_BLK-1:0] inuse_q, inuse_d;

    assign nolct_ok = inuse_q[curblk_q] && (32'(curblk_q) < NBLK);
    assign rtn_ok   = inuse_q[RTN_BLK] && (32'(RTN_BLK) < NBLK);

    always_comb begin
        inuse_d = inuse_q;
        if (nolct_push) begin
            inuse_d[curblk_q] = 1'b0;
        end
        if (rtn_push) begin
            inuse_d[RTN_BLK] = 1'b0;
        end
        if (free_pop) begin
            inuse_d[free_head] = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            inuse_q <= MAX_BLK'(1);
        end else begin
            inuse_q <= inuse_d;
        end
    end
`else
    assign nolct_ok = 1'b1;
    assign rtn_ok   = 1'b1;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            curblk_q  <= '0;
            nxtblk_q  <= '0;
            nxt_vld_q <= 1'b0;
            ovfl_q    <= 1'b0;
            rtn_ack_q <= 1'b0;
            dsca_q    <= DscaRst;
            dlsca_q   <= DlscaRst;
        end else begin
            curblk_q  <= curblk_d;
            nxtblk_q  <= nxtblk_d;
            nxt_vld_q <= nxt_vld_d;
            ovfl_q    <= ovfl_d;
            rtn_ack_q <= rtn_ack_d;
            dsca_q    <= dsca_d;
            dlsca_q   <= dlsca_d;
        end
    end

    blk_fifo #(
        .PRELOAD (1'b1),
        .NBLK    (NBLK),
        .TMR     (TMR)
    ) u_free (
        .CLK     (CLK),
        .RST     (RST),
        .push_i  (free_push),
        .din_i   (free_din),
        .pop_i   (free_pop),
        .dout_o  (free_head),
        .empty_o (free_empty),
        .cnt_o   (FREECNT),
        .cnt_d_o (free_cnt_d),
        .drop_o  (free_drop)
    );

    blk_fifo #(
        .PRELOAD (1'b0),
        .NBLK    (NBLK),
        .TMR     (TMR)
    ) u_dq (
        .CLK     (CLK),
        .RST     (RST),
        .push_i  (dq_push),
        .din_i   (curblk_q),
        .pop_i   (DQ_RD),
        .dout_o  (DQ_BLK),
        .empty_o (DQ_EMPTY),
        .cnt_o   (dq_cnt),
        .cnt_d_o (dq_cnt_d),
        .drop_o  (dq_drop)
    );

    assign unused_dq = ^{dq_cnt, dq_cnt_d};

    assign CURBLK    = curblk_q;
    assign OVFL      = ovfl_q;
    assign RTN_ACK   = rtn_ack_q;
    assign DSCAFULL  = dsca_q;
    assign DLSCAFULL = dlsca_q;

endmodule

// File: tb/tb_sca_blk_alloc.sv
// ---------------------------------------------------------------------------
// tb_sca_blk_alloc
// Self-checking bench for sca_blk_alloc: directed scenarios plus randomized
// controller/digitiser traffic, checked every cycle against a queue-based
// model of the block pool.
// ---------------------------------------------------------------------------
module tb_sca_blk_alloc;

    localparam int unsigned NBLK    = 12;
    localparam int unsigned LOWMARK = 2;
`ifdef SCA_BLK_DUPCHK_EN
    localparam bit DUP = 1'b1;
`else
    localparam bit DUP = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       nbsel = 1'b0, enareg = 1'b0, lct = 1'b0, nolct = 1'b0;
    logic       rtn_vld = 1'b0, dq_rd = 1'b0;
    logic [3:0] rtn_blk = '0;
    logic       rtn_ack, dq_empty, curblk_dummy, dsca, dlsca, ovfl;
    logic [3:0] dq_blk, curblk;
    logic [4:0] freecnt;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int free_q[$];
    int dq_q[$];
    int held[$];
    int m_cur, m_nxt;
    bit m_nv, m_ovfl, m_ack;
    bit m_inuse[16];

    always #5 CLK = ~CLK;

    sca_blk_alloc #(
        .NBLK    (NBLK),
        .LOWMARK (LOWMARK),
        .TMR     (0)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .NBSEL     (nbsel),
        .ENAREG    (enareg),
        .LCTYENA   (lct),
        .NOLCT     (nolct),
        .RTN_VLD   (rtn_vld),
        .RTN_BLK   (rtn_blk),
        .RTN_ACK   (rtn_ack),
        .DQ_RD     (dq_rd),
        .DQ_BLK    (dq_blk),
        .DQ_EMPTY  (dq_empty),
        .CURBLK    (curblk),
        .DSCAFULL  (dsca),
        .DLSCAFULL (dlsca),
        .OVFL      (ovfl),
        .FREECNT   (freecnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit blk_ok(input int b);
        if (!DUP) return 1'b1;
        return m_inuse[b] && (b < int'(NBLK));
    endfunction

    task automatic model_reset();
        free_q.delete();
        for (int b = 1; b < int'(NBLK); b++) free_q.push_back(b);
        dq_q.delete();
        held.delete();
        m_cur = 0; m_nxt = 0; m_nv = 0; m_ovfl = 0; m_ack = 0;
        for (int b = 0; b < 16; b++) m_inuse[b] = (b == 0);
    endtask

    // Advance the model by one cycle using the currently driven inputs.
    task automatic model_update();
        int old_cur = m_cur;
        int fsz = free_q.size();
        int dsz = dq_q.size();
        int rb = int'(rtn_blk);
        int popped = 0;
        bit pop_free, dq_pop_now, n_ok, r_ok, n_push, r_take, r_push;
        if (enareg) begin
            if (m_nv) m_cur = m_nxt;
            m_nv = 0;
        end
        pop_free = nbsel && (fsz > 0);
        if (nbsel) m_nv = pop_free;
        n_ok   = blk_ok(old_cur);
        r_ok   = blk_ok(rb);
        n_push = nolct && n_ok;
        r_take = rtn_vld && !n_push;
        r_push = r_take && r_ok;
        if ((nolct && !n_ok) || (r_take && !r_ok)) m_ovfl = 1;
        dq_pop_now = dq_rd && (dsz > 0);
        if (dq_pop_now) void'(dq_q.pop_front());
        if (lct) begin
            if (!m_nv) m_ovfl = 1;
            else if (dsz == 16 && !dq_pop_now) m_ovfl = 1;
            else dq_q.push_back(old_cur);
        end
        if (pop_free) begin
            popped = free_q.pop_front();
            m_nxt = popped;
        end
        if (n_push || r_push) begin
            if (fsz == 16 && !pop_free) m_ovfl = 1;
            else free_q.push_back(n_push ? old_cur : rb);
        end
        if (n_push) m_inuse[old_cur] = 0;
        if (r_push) m_inuse[rb] = 0;
        if (pop_free) m_inuse[popped] = 1;
        m_ack = r_take;
    endtask

    task automatic compare_all();
        chk("curblk", curblk, m_cur);
        chk("freecnt", freecnt, free_q.size());
        chk("dscafull", dsca, free_q.size() == 0);
        chk("dlscafull", dlsca, free_q.size() <= int'(LOWMARK));
        chk("dq_empty", dq_empty, dq_q.size() == 0);
        if (dq_q.size() > 0) chk("dq_blk", dq_blk, dq_q[0]);
        chk("ovfl", ovfl, m_ovfl);
        chk("rtn_ack", rtn_ack, m_ack);
    endtask

    task automatic step();
        model_update();
        @(posedge CLK);
        #1;
        compare_all();
    endtask

    task automatic ctl(input bit n, input bit e, input bit l, input bit no);
        nbsel = n; enareg = e; lct = l; nolct = no;
        step();
        nbsel = 0; enareg = 0; lct = 0; nolct = 0;
    endtask

    task automatic dq_pop();
        if (dq_q.size() > 0) held.push_back(dq_q[0]);
        dq_rd = 1;
        step();
        dq_rd = 0;
    endtask

    // Asynchronous reset, asserted away from the clock edge.
    task automatic do_reset();
        #3;
        RST = 1;
        nbsel = 0; enareg = 0; lct = 0; nolct = 0; dq_rd = 0; rtn_vld = 0; rtn_blk = '0;
        #1;
        model_reset();
        chk("rst_curblk", curblk, 0);
        chk("rst_freecnt", freecnt, NBLK - 1);
        chk("rst_dscafull", dsca, (NBLK - 1 == 0));
        chk("rst_dlscafull", dlsca, (NBLK - 1 <= LOWMARK));
        chk("rst_dq_empty", dq_empty, 1);
        chk("rst_dq_blk", dq_blk, 0);
        chk("rst_ovfl", ovfl, 0);
        chk("rst_rtn_ack", rtn_ack, 0);
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RST = 0;
    endtask

    task automatic rand_run(input int n);
        bit pend = 0;
        for (int i = 0; i < n; i++) begin
            int r;
            if (pend) begin
                enareg = 1;
                pend = 0;
            end else begin
                r = $urandom_range(0, 3);
                if (r != 0) begin
                    nbsel = 1;
                    pend = 1;
                    if (r == 1) lct = 1;
                    if (r == 2 && free_q.size() > 0) nolct = 1;
                end
            end
            dq_rd = (dq_q.size() > 0) && ($urandom_range(0, 2) == 0);
            if (dq_rd) held.push_back(dq_q[0]);
            if (!rtn_vld && held.size() > 0 && $urandom_range(0, 1) == 1) begin
                rtn_vld = 1;
                rtn_blk = 4'(held.pop_front());
            end
            step();
            if (m_ack) rtn_vld = 0;
            nbsel = 0; enareg = 0; lct = 0; nolct = 0; dq_rd = 0;
        end
    endtask

    initial begin
        do_reset();

        // LCT block goes to the digitise queue, next free block becomes current.
        ctl(1, 0, 1, 0);
        ctl(0, 1, 0, 0);
        chk("lct_dq_blk", dq_blk, 0);
        chk("lct_curblk", curblk, 1);
        chk("lct_freecnt", freecnt, 10);

        do_reset();
        // Non-LCT block recycled straight back to the free pool.
        ctl(1, 0, 0, 1);
        ctl(0, 1, 0, 0);
        chk("nolct_curblk", curblk, 1);
        chk("nolct_freecnt", freecnt, 11);
        chk("nolct_dq_empty", dq_empty, 1);

        do_reset();
        // Drain the whole pool with LCT cycles.
        for (int i = 0; i < 11; i++) begin
            ctl(1, 0, 1, 0);
            chk("drain_freecnt", freecnt, 10 - i);
            chk("drain_dlsca", dlsca, (10 - i) <= 2);
            chk("drain_dsca", dsca, (10 - i) == 0);
            ctl(0, 1, 0, 0);
        end
        ctl(1, 0, 1, 0);
        chk("lost_ovfl", ovfl, 1);
        ctl(0, 1, 0, 0);
        chk("lost_curblk", curblk, 11);
        for (int i = 0; i < 11; i++) begin
            chk("drain_dq_order", dq_blk, i);
            dq_pop();
        end
        chk("drain_dq_empty", dq_empty, 1);

        do_reset();
        // Return collides with a NOLCT push and must wait a cycle.
        for (int i = 0; i < 6; i++) begin
            ctl(1, 0, 1, 0);
            ctl(0, 1, 0, 0);
        end
        for (int i = 0; i < 6; i++) dq_pop();
        chk("coll_base", freecnt, 5);
        rtn_vld = 1;
        rtn_blk = 4'd5;
        ctl(0, 0, 0, 1);
        chk("coll_ack0", rtn_ack, 0);
        chk("coll_free1", freecnt, 6);
        step();
        chk("coll_ack1", rtn_ack, 1);
        chk("coll_free2", freecnt, 7);
        rtn_vld = 0;
        step();
        chk("coll_ack_pulse", rtn_ack, 0);

`ifdef SCA_BLK_DUPCHK_EN
        do_reset();
        // A block returned twice: second return is acked but rejected.
        for (int i = 0; i < 4; i++) begin
            ctl(1, 0, 1, 0);
            ctl(0, 1, 0, 0);
        end
        for (int i = 0; i < 4; i++) dq_pop();
        rtn_vld = 1;
        rtn_blk = 4'd3;
        step();
        chk("dup_ack1", rtn_ack, 1);
        chk("dup_free1", freecnt, 8);
        rtn_vld = 0;
        step();
        rtn_vld = 1;
        step();
        chk("dup_ack2", rtn_ack, 1);
        chk("dup_free2", freecnt, 8);
        chk("dup_ovfl", ovfl, 1);
        rtn_vld = 0;
        step();
`endif

        do_reset();
        rand_run(600);
        do_reset();
        rand_run(600);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Spare signal tied low so it is never left floating.
    assign curblk_dummy = 1'b0;

endmodule
